branch_redirect_controller: RTL

Sequences PC recovery after a branch misprediction in the 5-stage core. It sits beside the branch prediction unit at the EX stage: it captures a resolved misprediction and the recovery offset, issues a single redirect to the PC with IF/ID flushes, then masks wrong-path resolutions for a configurable squash window. It also honours pipeline stall and halt, and optionally keeps branch/mispredict statistics.

---
 rtl/branch_redirect_controller.sv | 117 +++++++++++
 1 files changed

// File: rtl/branch_redirect_controller.sv
// Branch misprediction recovery sequencer: capture -> single redirect with IF/ID flush -> squash window.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_redirect_controller #(
  parameter int OFFSET_W      = 17,
  parameter int SQUASH_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                halted,
  input  logic                ex_valid,
  input  logic                ex_is_branch,
  input  logic                ex_is_jal,
  input  logic                ex_mispredict,
  input  logic [OFFSET_W-1:0] ex_recover_offset,
  output logic                redirect_valid,
  output logic [OFFSET_W-1:0] redirect_offset,
  output logic                flush_if,
  output logic                flush_id,
  output logic                busy,
  output logic [CNT_W-1:0]    branch_count,
  output logic [CNT_W-1:0]    mispredict_count
);

  typedef enum logic [1:0] {IDLE, REDIRECT, SQUASH} state_t;

  localparam logic [3:0] SQ_LOAD = 4'(SQUASH_CYCLES - 1);

  state_t              state_q, state_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic [3:0]          sq_cnt_q, sq_cnt_d;
  logic                resolve;
  logic                capture;
  logic                advance;

  assign resolve = ex_valid & (ex_is_branch | ex_is_jal);
  assign capture = resolve & ex_mispredict & ~halted;
  assign advance = ~stall & ~halted;

  // Capture is allowed under stall because EX contents are held stable.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    sq_cnt_d = sq_cnt_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          offset_d = ex_recover_offset;
          state_d  = REDIRECT;
        end
      end
      REDIRECT: begin
        if (advance) begin
          state_d  = SQUASH;
          sq_cnt_d = SQ_LOAD;
        end
      end
      SQUASH: begin
        if (advance) begin
          if (sq_cnt_q == 4'd0) begin
            state_d = IDLE;
          end else begin
            sq_cnt_d = sq_cnt_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      offset_q <= '0;
      sq_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      sq_cnt_q <= sq_cnt_d;
    end
  end

  assign redirect_valid  = (state_q == REDIRECT);
  assign flush_if        = (state_q == REDIRECT);
  assign flush_id        = (state_q == REDIRECT);
  assign redirect_offset = offset_q;
  assign busy            = (state_q != IDLE);

`ifdef BRANCH_STATS_EN
  logic             br_inc;
  logic             mp_inc;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] mp_cnt_q;

  assign br_inc = (state_q == IDLE) & resolve & advance;
  assign mp_inc = (state_q == IDLE) & capture & ~stall;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      if (br_inc && (br_cnt_q != '1)) br_cnt_q <= br_cnt_q + 1'b1;
      if (mp_inc && (mp_cnt_q != '1)) mp_cnt_q <= mp_cnt_q + 1'b1;
    end
  end

  assign branch_count     = br_cnt_q;
  assign mispredict_count = mp_cnt_q;
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif

endmodule
